// File: rtl/id_ex_issue_stage_if.sv
// Signal bundle for the ID/EX issue stage.
// Covers the decode side, the ALU side and the downstream forwarding sources.
interface id_ex_issue_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 4
);
    logic              id_valid;
    logic [DATA_W-1:0] id_op1;
    logic [DATA_W-1:0] id_op2;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic [CTRL_W-1:0] id_ctrl;
    logic [REG_AW-1:0] id_rd;
    logic              id_wr_en;
    logic              id_is_load;
    logic              id_ready;
    logic              ex_stall;
    logic              flush;
    logic [31:0]       alu_result;
    logic              mem_wr_en;
    logic [REG_AW-1:0] mem_rd;
    logic [31:0]       mem_data;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_op1;
    logic [DATA_W-1:0] ex_op2;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_wr_en;
    logic              ex_is_load;
    logic [15:0]       bubble_cnt;

    modport master (
        output id_valid, id_op1, id_op2, id_rs, id_rt, id_rs_used, id_rt_used,
               id_ctrl, id_rd, id_wr_en, id_is_load, ex_stall, flush,
               alu_result, mem_wr_en, mem_rd, mem_data,
        input  id_ready, ex_valid, ex_op1, ex_op2, ex_ctrl, ex_rd, ex_wr_en,
               ex_is_load, bubble_cnt
    );

    modport slave (
        input  id_valid, id_op1, id_op2, id_rs, id_rt, id_rs_used, id_rt_used,
               id_ctrl, id_rd, id_wr_en, id_is_load, ex_stall, flush,
               alu_result, mem_wr_en, mem_rd, mem_data,
        output id_ready, ex_valid, ex_op1, ex_op2, ex_ctrl, ex_rd, ex_wr_en,
               ex_is_load, bubble_cnt
    );
endinterface

// File: rtl/id_ex_issue_stage.sv
// ID/EX register feeding the ALU: operand forwarding, hazard bubbles, stall and flush.
// Define ID_EX_FWD_EN for EX/MEM forwarding; otherwise every RAW hazard waits for the regfile.
module id_ex_issue_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    id_ex_issue_stage_if.slave bus
);
    logic              ex_valid_reg, ex_valid_next;
    logic [DATA_W-1:0] ex_op1_reg, ex_op2_reg;
    logic [CTRL_W-1:0] ex_ctrl_reg;
    logic [REG_AW-1:0] ex_rd_reg;
    logic              ex_wr_en_reg, ex_is_load_reg;
    logic [15:0]       bubble_cnt_reg, bubble_cnt_next;

    logic                   ex_prod, mem_prod;
    logic [1:0]             src_used, hit_ex, hit_mem;
    logic [1:0][REG_AW-1:0] src_addr;
    logic [1:0][DATA_W-1:0] src_val, opnd_val;
    logic                   bubble, capture, ready;

    // Register 0 never counts as a producer, so it can neither forward nor stall.
    assign ex_prod  = ex_valid_reg & ex_wr_en_reg & (ex_rd_reg != '0);
    assign mem_prod = bus.mem_wr_en & (bus.mem_rd != '0);

    assign src_used = {bus.id_rt_used, bus.id_rs_used};
    assign src_addr = {bus.id_rt, bus.id_rs};
    assign src_val  = {bus.id_op2, bus.id_op1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            assign hit_ex[gi]  = src_used[gi] & ex_prod  & (src_addr[gi] == ex_rd_reg);
            assign hit_mem[gi] = src_used[gi] & mem_prod & (src_addr[gi] == bus.mem_rd);
`ifdef ID_EX_FWD_EN
            // Youngest producer wins; the ALU only sees the low DATA_W bits.
            assign opnd_val[gi] = hit_ex[gi]  ? bus.alu_result[DATA_W-1:0] :
                                  hit_mem[gi] ? bus.mem_data[DATA_W-1:0]   :
                                                src_val[gi];
`else
            assign opnd_val[gi] = src_val[gi];
`endif
        end
    endgenerate

`ifdef ID_EX_FWD_EN
    // A load result is not available until MEM, so only load-use must wait.
    assign bubble = bus.id_valid & ex_is_load_reg & (|hit_ex);

    logic unused_hi;
    assign unused_hi = ^{bus.alu_result[31:DATA_W], bus.mem_data[31:DATA_W]};
`else
    // Without forwarding the consumer waits until the producer has left MEM.
    assign bubble = bus.id_valid & ((|hit_ex) | (|hit_mem));

    logic unused_data;
    assign unused_data = ^{bus.alu_result, bus.mem_data};
`endif

    always_comb begin
        ready           = 1'b1;
        capture         = 1'b0;
        ex_valid_next   = ex_valid_reg;
        bubble_cnt_next = bubble_cnt_reg;
        if (bus.flush) begin
            ex_valid_next = 1'b0;
        end else if (bus.ex_stall) begin
            ready = 1'b0;
        end else if (bubble) begin
            ready         = 1'b0;
            ex_valid_next = 1'b0;
            if (bubble_cnt_reg != 16'hFFFF) begin
                bubble_cnt_next = bubble_cnt_reg + 16'd1;
            end
        end else begin
            capture       = bus.id_valid;
            ex_valid_next = bus.id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_reg   <= 1'b0;
            ex_op1_reg     <= '0;
            ex_op2_reg     <= '0;
            ex_ctrl_reg    <= '0;
            ex_rd_reg      <= '0;
            ex_wr_en_reg   <= 1'b0;
            ex_is_load_reg <= 1'b0;
            bubble_cnt_reg <= '0;
        end else begin
            ex_valid_reg   <= ex_valid_next;
            bubble_cnt_reg <= bubble_cnt_next;
            if (capture) begin
                ex_op1_reg     <= opnd_val[0];
                ex_op2_reg     <= opnd_val[1];
                ex_ctrl_reg    <= bus.id_ctrl;
                ex_rd_reg      <= bus.id_rd;
                ex_wr_en_reg   <= bus.id_wr_en;
                ex_is_load_reg <= bus.id_is_load;
            end
        end
    end

    assign bus.id_ready   = ready;
    assign bus.ex_valid   = ex_valid_reg;
    assign bus.ex_op1     = ex_op1_reg;
    assign bus.ex_op2     = ex_op2_reg;
    assign bus.ex_ctrl    = ex_ctrl_reg;
    assign bus.ex_rd      = ex_rd_reg;
    assign bus.ex_wr_en   = ex_wr_en_reg;
    assign bus.ex_is_load = ex_is_load_reg;
    assign bus.bubble_cnt = bubble_cnt_reg;
endmodule

// File: tb/tb_id_ex_issue_stage.sv
// Bench for id_ex_issue_stage: vector table, hand-written hazard sequences, random vs model.
// Expectations follow ID_EX_FWD_EN the same way the design does.
`timescale 1ns/1ps
module tb_id_ex_issue_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_issue_stage_if bus ();
    id_ex_issue_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic        valid;
        logic [15:0] op1, op2;
        logic [4:0]  rs, rt;
        logic        rsu, rtu;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        wr, ld, stall, flush;
        logic [31:0] alu;
        logic        mem_wr;
        logic [4:0]  mem_rd;
        logic [31:0] mem_data;
    } in_t;

    typedef struct {
        in_t         in;
        logic        exp_ready, exp_valid;
        logic [15:0] exp_op1, exp_op2;
        logic [3:0]  exp_ctrl;
        logic [4:0]  exp_rd;
        logic        exp_wr;
        logic [15:0] exp_bub;
    } vec_t;

    typedef struct {
        bit          v;
        logic [15:0] op1, op2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        bit          wr, ld;
    } slot_t;

    int    checks = 0;
    int    errors = 0;
    vec_t  vecs[$];
    slot_t m;
    int    m_bub;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic in_t idle();
        in_t i;
        i.valid = 1'b0; i.op1 = '0; i.op2 = '0; i.rs = '0; i.rt = '0;
        i.rsu = 1'b0; i.rtu = 1'b0; i.ctrl = '0; i.rd = '0; i.wr = 1'b0;
        i.ld = 1'b0; i.stall = 1'b0; i.flush = 1'b0; i.alu = '0;
        i.mem_wr = 1'b0; i.mem_rd = '0; i.mem_data = '0;
        return i;
    endfunction

    function automatic in_t instr(int op1, int op2, int rs, int rt, int rsu, int rtu,
                                  int ctrl, int rd, int wr, int ld);
        in_t i;
        i = idle();
        i.valid = 1'b1;  i.op1 = 16'(op1); i.op2 = 16'(op2);
        i.rs = 5'(rs);   i.rt = 5'(rt);    i.rsu = 1'(rsu); i.rtu = 1'(rtu);
        i.ctrl = 4'(ctrl); i.rd = 5'(rd);  i.wr = 1'(wr);   i.ld = 1'(ld);
        return i;
    endfunction

    task automatic add(in_t i, int rdy, int v, int op1, int op2, int ctrl, int rd, int wr, int bub);
        vec_t x;
        x.in = i; x.exp_ready = 1'(rdy); x.exp_valid = 1'(v);
        x.exp_op1 = 16'(op1); x.exp_op2 = 16'(op2); x.exp_ctrl = 4'(ctrl);
        x.exp_rd = 5'(rd); x.exp_wr = 1'(wr); x.exp_bub = 16'(bub);
        vecs.push_back(x);
    endtask

    task automatic drive(in_t i);
        bus.id_valid = i.valid;   bus.id_op1 = i.op1;       bus.id_op2 = i.op2;
        bus.id_rs = i.rs;         bus.id_rt = i.rt;         bus.id_rs_used = i.rsu;
        bus.id_rt_used = i.rtu;   bus.id_ctrl = i.ctrl;     bus.id_rd = i.rd;
        bus.id_wr_en = i.wr;      bus.id_is_load = i.ld;    bus.ex_stall = i.stall;
        bus.flush = i.flush;      bus.alu_result = i.alu;   bus.mem_wr_en = i.mem_wr;
        bus.mem_rd = i.mem_rd;    bus.mem_data = i.mem_data;
    endtask

    task automatic do_reset();
        in_t i;
        i = idle();
        i.valid = 1'b1;
        drive(i);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One hand-driven cycle: apply inputs, check combinational id_ready, then clock.
    task automatic step(string tag, in_t i, int exp_ready);
        drive(i);
        #1;
        chk({tag, "_ready"}, 32'(bus.id_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
        $display("%s: valid=%0b op1=%h op2=%h bub=%0d", tag, bus.ex_valid, bus.ex_op1,
                 bus.ex_op2, bus.bubble_cnt);
    endtask

    task automatic chk_out(string tag, int v, int op1, int bub);
        chk({tag, "_valid"}, 32'(bus.ex_valid), 32'(v));
        chk({tag, "_bub"}, 32'(bus.bubble_cnt), 32'(bub));
        if (v != 0) chk({tag, "_op1"}, 32'(bus.ex_op1), 32'(op1));
    endtask

    // Reference model: operand value and bubble decision straight from the hazard rules.
    function automatic bit reads(in_t i, logic [4:0] r);
        return (r != 5'd0) && ((i.rsu && i.rs == r) || (i.rtu && i.rt == r));
    endfunction

    function automatic logic [15:0] pick(in_t i, slot_t s, bit used, logic [4:0] r,
                                         logic [15:0] rf);
        if (FWD && used && r != 5'd0) begin
            if (s.v && s.wr && s.rd == r) return i.alu[15:0];
            if (i.mem_wr && i.mem_rd == r) return i.mem_data[15:0];
        end
        return rf;
    endfunction

    function automatic bit must_bubble(in_t i, slot_t s);
        bit dep_ex, dep_mem;
        dep_ex  = s.v && s.wr && reads(i, s.rd);
        dep_mem = i.mem_wr && reads(i, i.mem_rd);
        if (!i.valid) return 1'b0;
        return FWD ? (dep_ex && s.ld) : (dep_ex || dep_mem);
    endfunction

    function automatic in_t rnd_in();
        in_t i;
        i.valid    = ($urandom_range(3) != 0);
        i.op1      = 16'($urandom);
        i.op2      = 16'($urandom);
        i.rs       = 5'($urandom_range(3));
        i.rt       = 5'($urandom_range(3));
        i.rsu      = 1'($urandom_range(1));
        i.rtu      = 1'($urandom_range(1));
        i.ctrl     = 4'($urandom);
        i.rd       = 5'($urandom_range(3));
        i.wr       = ($urandom_range(3) != 0);
        i.ld       = ($urandom_range(2) == 0);
        i.stall    = ($urandom_range(7) == 0);
        i.flush    = ($urandom_range(15) == 0);
        i.alu      = $urandom;
        i.mem_wr   = 1'($urandom_range(1));
        i.mem_rd   = 5'($urandom_range(3));
        i.mem_data = $urandom;
        return i;
    endfunction

    initial begin
        in_t t, c;
        slot_t nx;
        bit bub, rdy;

        // Reset with id_valid held high
        do_reset();
        chk("rst_valid", 32'(bus.ex_valid), 0);
        chk("rst_bub", 32'(bus.bubble_cnt), 0);
        chk("rst_op1", 32'(bus.ex_op1), 0);
        chk("rst_op2", 32'(bus.ex_op2), 0);
        chk("rst_ctrl", 32'(bus.ex_ctrl), 0);
        chk("rst_rd", 32'(bus.ex_rd), 0);
        chk("rst_wr", 32'(bus.ex_wr_en), 0);
        chk("rst_ld", 32'(bus.ex_is_load), 0);
        $display("reset: valid=%0b bub=%0d", bus.ex_valid, bus.bubble_cnt);

        // Vector table: behaviour common to both configurations
        t = instr('h1111, 'h2222, 1, 2, 1, 1, 3, 6, 1, 0);
        add(t, 1, 1, 'h1111, 'h2222, 3, 6, 1, 0);
        t = instr('hAAAA, 'h000F, 7, 6, 1, 0, 5, 8, 1, 0); t.alu = 32'h0000_DEAD;
        add(t, 1, 1, 'hAAAA, 'h000F, 5, 8, 1, 0);
        t = idle();
        add(t, 1, 0, 0, 0, 0, 0, 0, 0);
        t = instr('h0123, 'h0000, 9, 0, 1, 0, 1, 0, 1, 0);
        add(t, 1, 1, 'h0123, 0, 1, 0, 1, 0);
        t = instr(0, 0, 0, 0, 1, 1, 2, 10, 1, 0);
        t.alu = 32'h1234_5678; t.mem_wr = 1'b1; t.mem_rd = 5'd0; t.mem_data = 32'h0000_9999;
        add(t, 1, 1, 0, 0, 2, 10, 1, 0);
        t = instr('h5555, 'h6666, 10, 10, 1, 1, 7, 11, 1, 1); t.stall = 1'b1;
        for (int k = 0; k < 3; k++) add(t, 0, 1, 0, 0, 2, 10, 1, 0);
        t.flush = 1'b1;
        add(t, 1, 0, 0, 0, 0, 0, 0, 0);
        t = instr('hBEEF, 'h0001, 11, 0, 1, 0, 9, 12, 0, 0);
        add(t, 1, 1, 'hBEEF, 'h0001, 9, 12, 0, 0);
        t.flush = 1'b1;
        add(t, 1, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].in);
            #1;
            chk($sformatf("vec%0d_ready", k), 32'(bus.id_ready), 32'(vecs[k].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", k), 32'(bus.ex_valid), 32'(vecs[k].exp_valid));
            chk($sformatf("vec%0d_bub", k), 32'(bus.bubble_cnt), 32'(vecs[k].exp_bub));
            if (vecs[k].exp_valid) begin
                chk($sformatf("vec%0d_op1", k), 32'(bus.ex_op1), 32'(vecs[k].exp_op1));
                chk($sformatf("vec%0d_op2", k), 32'(bus.ex_op2), 32'(vecs[k].exp_op2));
                chk($sformatf("vec%0d_ctrl", k), 32'(bus.ex_ctrl), 32'(vecs[k].exp_ctrl));
                chk($sformatf("vec%0d_rd", k), 32'(bus.ex_rd), 32'(vecs[k].exp_rd));
                chk($sformatf("vec%0d_wr", k), 32'(bus.ex_wr_en), 32'(vecs[k].exp_wr));
            end
            $display("vec%0d: ready=%0b valid=%0b op1=%h op2=%h bub=%0d", k, bus.id_ready,
                     bus.ex_valid, bus.ex_op1, bus.ex_op2, bus.bubble_cnt);
        end

        // Hand-written multi-cycle hazard sequences
        step("idle", idle(), 1);
`ifdef ID_EX_FWD_EN
        step("add_r3", instr(1, 2, 1, 2, 1, 1, 0, 3, 1, 0), 1);
        c = instr(0, 3, 3, 2, 1, 1, 0, 14, 1, 0); c.alu = 32'h0000_0005;
        step("fwd_ex", c, 1);
        chk_out("fwd_ex", 1, 'h0005, 0);
        chk("fwd_ex_op2", 32'(bus.ex_op2), 3);
        step("add_r4", instr(0, 0, 1, 1, 1, 1, 0, 4, 1, 0), 1);
        c = instr(0, 0, 4, 0, 1, 0, 1, 13, 1, 0);
        c.alu = 32'd7; c.mem_wr = 1'b1; c.mem_rd = 5'd4; c.mem_data = 32'd9;
        step("prio_ex", c, 1);
        chk_out("prio_ex", 1, 7, 0);
        c.rd = 5'd15;
        step("prio_mem", c, 1);
        chk_out("prio_mem", 1, 9, 0);
        step("load_r2", instr(0, 0, 1, 1, 1, 1, 0, 2, 1, 1), 1);
        c = instr(0, 0, 2, 0, 1, 0, 2, 6, 1, 0); c.alu = 32'h0000_DEAD;
        step("lu_bubble", c, 0);
        chk_out("lu_bubble", 0, 0, 1);
        c.mem_wr = 1'b1; c.mem_rd = 5'd2; c.mem_data = 32'h0000_4242;
        step("lu_mem", c, 1);
        chk_out("lu_mem", 1, 'h4242, 1);
        step("load_r2b", instr(0, 0, 1, 1, 1, 1, 0, 2, 1, 1), 1);
        c.mem_wr = 1'b0; c.flush = 1'b1;
        step("lu_flush", c, 1);
        chk_out("lu_flush", 0, 0, 1);
`else
        step("add_r3", instr(1, 2, 1, 2, 1, 1, 0, 3, 1, 0), 1);
        c = instr(0, 3, 3, 2, 1, 1, 0, 14, 1, 0); c.alu = 32'h0000_0005;
        step("dep_ex", c, 0);
        chk_out("dep_ex", 0, 0, 1);
        c.mem_wr = 1'b1; c.mem_rd = 5'd3; c.mem_data = 32'h0000_0005;
        step("dep_mem", c, 0);
        chk_out("dep_mem", 0, 0, 2);
        c.mem_wr = 1'b0; c.op1 = 16'h0005;
        step("dep_rf", c, 1);
        chk_out("dep_rf", 1, 'h0005, 2);
        step("load_r2", instr(0, 0, 1, 1, 1, 1, 0, 2, 1, 1), 1);
        c = instr(0, 0, 9, 2, 1, 1, 2, 6, 1, 0);
        step("lu_ex", c, 0);
        chk_out("lu_ex", 0, 0, 3);
        c.mem_wr = 1'b1; c.mem_rd = 5'd2; c.mem_data = 32'h0000_4242;
        step("lu_mem", c, 0);
        chk_out("lu_mem", 0, 0, 4);
        c.mem_wr = 1'b0; c.op2 = 16'h4242;
        step("lu_rf", c, 1);
        chk_out("lu_rf", 1, 0, 4);
        chk("lu_rf_op2", 32'(bus.ex_op2), 'h4242);
        step("add_r5", instr(0, 0, 1, 1, 1, 1, 0, 5, 1, 0), 1);
        c = instr(0, 0, 5, 0, 1, 0, 2, 6, 1, 0); c.flush = 1'b1;
        step("haz_flush", c, 1);
        chk_out("haz_flush", 0, 0, 4);
`endif

        // Random traffic against the reference model
        do_reset();
        m = '{default: 0};
        m_bub = 0;
        for (int n = 0; n < 2000; n++) begin
            t = rnd_in();
            drive(t);
            #1;
            bub = must_bubble(t, m);
            nx = m;
            if (t.flush) begin
                rdy = 1'b1; nx.v = 1'b0;
            end else if (t.stall) begin
                rdy = 1'b0;
            end else if (bub) begin
                rdy = 1'b0; nx.v = 1'b0;
                if (m_bub < 65535) m_bub++;
            end else begin
                rdy = 1'b1; nx.v = t.valid;
                if (t.valid) begin
                    nx.op1  = pick(t, m, t.rsu, t.rs, t.op1);
                    nx.op2  = pick(t, m, t.rtu, t.rt, t.op2);
                    nx.ctrl = t.ctrl; nx.rd = t.rd; nx.wr = t.wr; nx.ld = t.ld;
                end
            end
            chk($sformatf("rnd%0d_ready", n), 32'(bus.id_ready), 32'(rdy));
            @(posedge clk);
            #1;
            m = nx;
            chk($sformatf("rnd%0d_valid", n), 32'(bus.ex_valid), 32'(m.v));
            chk($sformatf("rnd%0d_bub", n), 32'(bus.bubble_cnt), 32'(m_bub));
            if (m.v) begin
                chk($sformatf("rnd%0d_op1", n), 32'(bus.ex_op1), 32'(m.op1));
                chk($sformatf("rnd%0d_op2", n), 32'(bus.ex_op2), 32'(m.op2));
                chk($sformatf("rnd%0d_ctrl", n), 32'(bus.ex_ctrl), 32'(m.ctrl));
                chk($sformatf("rnd%0d_rd", n), 32'(bus.ex_rd), 32'(m.rd));
                chk($sformatf("rnd%0d_wr", n), 32'(bus.ex_wr_en), 32'(m.wr));
                chk($sformatf("rnd%0d_ld", n), 32'(bus.ex_is_load), 32'(m.ld));
            end
            $display("rnd%0d: ready=%0b valid=%0b op1=%h op2=%h bub=%0d", n, rdy,
                     bus.ex_valid, bus.ex_op1, bus.ex_op2, bus.bubble_cnt);
        end

`ifndef ID_EX_FWD_EN
        // Bubble counter saturation: a MEM producer held forever keeps the consumer waiting
        do_reset();
        t = instr(0, 0, 5, 0, 1, 0, 0, 6, 1, 0);
        t.mem_wr = 1'b1; t.mem_rd = 5'd5;
        drive(t);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", 32'(bus.bubble_cnt), 'hFFFE);
        @(posedge clk);
        #1;
        chk("sat_ffff", 32'(bus.bubble_cnt), 'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_hold", 32'(bus.bubble_cnt), 'hFFFF);
        chk("sat_valid", 32'(bus.ex_valid), 0);
        $display("saturation: bub=%h", bus.bubble_cnt);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
